trans_rd_addr_gen: RTL and testbench

- Read-side sequencer for the inter-layer transfer buffer in the L10–L17 datapath.
- The write path presents a registered write strobe and two 10-bit transfer addresses. This block is the matching reader: after a start command it walks the buffer and issues a registered read strobe with two 10-bit read addresses per beat.
- The two addresses serve the buffer's two read ports: port 1 at base+i, port 2 at base+OFFSET+i.
- Output beats are stalled by downstream backpressure using a valid/ready handshake.

---
 rtl/trans_rd_addr_gen.sv | 146 ++++++++++++++
 tb/tb_trans_rd_addr_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_rd_addr_gen.sv
// Read-side sequencer for the inter-layer transfer buffer: after a start command it walks
// the buffer, presenting paired port-1/port-2 read addresses under a valid/ready handshake.
module trans_rd_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] offset,
    input  logic [LEN_W-1:0]  length,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] REG_RD_ADDR1,
    output logic [ADDR_W-1:0] REG_RD_ADDR2,
    output logic              REG_READ,
    output logic              REG_LAST,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [ADDR_W-1:0] addr2_q, addr2_d;
    logic              read_q, read_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic [LEN_W-1:0]  cnt_inc;
    logic [LEN_W-1:0]  len_in;

    // A buffer of 2^ADDR_W entries can never hold more beats than that.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    assign accept  = read_q & rd_ready;
    assign cnt_inc = cnt_q + LEN_W'(1);
    assign len_in  = clamp_len(length);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        offset_d = offset_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr1_d  = addr1_q;
        addr2_d  = addr2_q;
        read_d   = read_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    offset_d = offset;
                    len_d    = len_in;
                    cnt_d    = '0;
                    if (len_in == '0) begin
                        state_d = FIN;
                    end else begin
                        // First beat is loaded on the accepting edge itself.
                        state_d = RUN;
                        addr1_d = base_addr;
                        addr2_d = base_addr + offset;
                        read_d  = 1'b1;
                        last_d  = (len_in == LEN_W'(1));
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_q) begin
                        read_d  = 1'b0;
                        last_d  = 1'b0;
                        state_d = FIN;
                    end else begin
                        cnt_d   = cnt_inc;
                        addr1_d = base_q + cnt_inc[ADDR_W-1:0];
                        addr2_d = base_q + offset_q + cnt_inc[ADDR_W-1:0];
                        last_d  = (cnt_inc == len_q - LEN_W'(1));
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            offset_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            addr1_q  <= '0;
            addr2_q  <= '0;
            read_q   <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr1_q  <= addr1_d;
            addr2_q  <= addr2_d;
            read_q   <= read_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign REG_RD_ADDR1 = addr1_q;
    assign REG_RD_ADDR2 = addr2_q;
    assign REG_READ     = read_q;
    assign REG_LAST     = last_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_trans_rd_addr_gen.sv
// Scoreboard bench for trans_rd_addr_gen: expected beats are queued when a command is
// issued and popped as the DUT hands over accepted beats.
module tb_trans_rd_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [9:0]  offset = '0;
    logic [10:0] length = '0;
    logic        rd_ready = 1'b0;
    logic [9:0]  REG_RD_ADDR1, REG_RD_ADDR2;
    logic        REG_READ, REG_LAST, busy, done;

    typedef struct packed {
        logic [9:0] a1;
        logic [9:0] a2;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   beats_total = 0;
    int   done_total = 0;
    int   busy_total = 0;
    int   last_done_cyc = -1;
    int   first_beat_cyc = -1;
    logic prev_read = 1'b0;

    trans_rd_addr_gen #(.ADDR_W(10), .LEN_W(11)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .offset(offset),
        .length(length), .rd_ready(rd_ready), .REG_RD_ADDR1(REG_RD_ADDR1),
        .REG_RD_ADDR2(REG_RD_ADDR2), .REG_READ(REG_READ), .REG_LAST(REG_LAST),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic monitor_beats();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst && REG_READ && rd_ready) begin
                beats_total++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got a1=%h a2=%h last=%b, required no beat",
                             REG_RD_ADDR1, REG_RD_ADDR2, REG_LAST);
                end else begin
                    e = exp_q.pop_front();
                    if ({REG_RD_ADDR1, REG_RD_ADDR2, REG_LAST} !== e) begin
                        fails++;
                        $display("FAIL beat_data: got a1=%h a2=%h last=%b, required a1=%h a2=%h last=%b",
                                 REG_RD_ADDR1, REG_RD_ADDR2, REG_LAST, e.a1, e.a2, e.last);
                    end
                end
            end
            if (done) begin
                done_total++;
                last_done_cyc = cyc;
            end
            if (busy) busy_total++;
            if (REG_READ && !prev_read) first_beat_cyc = cyc;
            prev_read = REG_READ;
        end
    endtask

    task automatic issue(input logic [9:0] b, input logic [9:0] o, input logic [10:0] l,
                         output int n);
        logic [10:0] eff;
        logic [9:0]  a1, a2;
        logic        lst;
        eff = (l > 11'd1024) ? 11'd1024 : l;
        @(posedge clk); #1;
        n = cyc;
        start = 1'b1; base_addr = b; offset = o; length = l;
        for (int i = 0; i < int'(eff); i++) begin
            a1  = b + 10'(i);
            a2  = b + o + 10'(i);
            lst = (i == int'(eff) - 1);
            exp_q.push_back({a1, a2, lst});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            if (done_total != d0) return;
            @(negedge clk); #1;
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: done count %0d after %0d cycles, required a new done", name, done_total, budget);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({REG_RD_ADDR1, REG_RD_ADDR2, REG_READ, REG_LAST, busy, done} !== 24'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {REG_RD_ADDR1, REG_RD_ADDR2, REG_READ, REG_LAST, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int n, d0, b0, z0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total; z0 = busy_total;
        issue(10'h010, 10'h100, 11'd4, n);
        wait_done(d0, 20, "basic");
        repeat (2) @(negedge clk);
        tests++;
        if (first_beat_cyc !== n + 1) begin fails++; $display("FAIL basic_first_beat: got cycle %0d, required %0d", first_beat_cyc, n + 1); end
        tests++;
        if (last_done_cyc !== n + 5) begin fails++; $display("FAIL basic_done_cycle: got %0d, required %0d", last_done_cyc, n + 5); end
        tests++;
        if (beats_total - b0 !== 4) begin fails++; $display("FAIL basic_beats: got %0d, required 4", beats_total - b0); end
        tests++;
        if (busy_total - z0 !== 4) begin fails++; $display("FAIL basic_busy_cycles: got %0d, required 4", busy_total - z0); end
        tests++;
        if (done_total - d0 !== 1) begin fails++; $display("FAIL basic_done_count: got %0d, required 1", done_total - d0); end
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL basic_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int n, d0, b0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total;
        issue(10'h010, 10'h100, 11'd4, n);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            tests++;
            if ({REG_READ, REG_RD_ADDR1, REG_RD_ADDR2, REG_LAST} !== {1'b1, 10'h011, 10'h111, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold: got read=%b a1=%h a2=%h last=%b, required read=1 a1=011 a2=111 last=0",
                         REG_READ, REG_RD_ADDR1, REG_RD_ADDR2, REG_LAST);
            end
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        wait_done(d0, 30, "stall");
        repeat (2) @(negedge clk);
        tests++;
        if (last_done_cyc !== n + 8) begin fails++; $display("FAIL stall_done_cycle: got %0d, required %0d", last_done_cyc, n + 8); end
        tests++;
        if (beats_total - b0 !== 4) begin fails++; $display("FAIL stall_beats: got %0d, required 4", beats_total - b0); end
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL stall_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int n, d0, b0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total;
        issue(10'h3FE, 10'h3FF, 11'd3, n);
        wait_done(d0, 20, "wrap");
        repeat (2) @(negedge clk);
        tests++;
        if (beats_total - b0 !== 3) begin fails++; $display("FAIL wrap_beats: got %0d, required 3", beats_total - b0); end
        tests++;
        if (last_done_cyc !== n + 4) begin fails++; $display("FAIL wrap_done_cycle: got %0d, required %0d", last_done_cyc, n + 4); end
    endtask

    task automatic test_zero_len();
        int n, d0, b0, z0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total; z0 = busy_total;
        issue(10'h123, 10'h001, 11'd0, n);
        wait_done(d0, 20, "zero");
        repeat (3) @(negedge clk);
        tests++;
        if (beats_total - b0 !== 0) begin fails++; $display("FAIL zero_beats: got %0d, required 0", beats_total - b0); end
        tests++;
        if (last_done_cyc !== n + 1) begin fails++; $display("FAIL zero_done_cycle: got %0d, required %0d", last_done_cyc, n + 1); end
        tests++;
        if (busy_total - z0 !== 0) begin fails++; $display("FAIL zero_busy: got %0d, required 0", busy_total - z0); end
    endtask

    task automatic test_ignored_start();
        int n, d0, b0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total;
        issue(10'h200, 10'h010, 11'd5, n);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h3AA; length = 11'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0, 20, "ignore");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (beats_total - b0 !== 5) begin fails++; $display("FAIL ignore_beats: got %0d, required 5", beats_total - b0); end
        tests++;
        if (done_total - d0 !== 1) begin fails++; $display("FAIL ignore_done_count: got %0d, required 1", done_total - d0); end
        tests++;
        if (last_done_cyc !== n + 6) begin fails++; $display("FAIL ignore_done_cycle: got %0d, required %0d", last_done_cyc, n + 6); end
    endtask

    task automatic test_clamp();
        int n, d0, b0;
        rd_ready = 1'b1;
        d0 = done_total; b0 = beats_total;
        issue(10'h000, 10'h200, 11'd1100, n);
        wait_done(d0, 1100, "clamp");
        repeat (2) @(negedge clk);
        tests++;
        if (beats_total - b0 !== 1024) begin fails++; $display("FAIL clamp_beats: got %0d, required 1024", beats_total - b0); end
        tests++;
        if (last_done_cyc !== n + 1025) begin fails++; $display("FAIL clamp_done_cycle: got %0d, required %0d", last_done_cyc, n + 1025); end
    endtask

    task automatic test_async_reset();
        int n, d0, b0;
        rd_ready = 1'b1;
        d0 = done_total;
        issue(10'h040, 10'h020, 11'd8, n);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        tests++;
        if ({REG_RD_ADDR1, REG_RD_ADDR2, REG_READ, REG_LAST, busy, done} !== 24'd0) begin
            fails++;
            $display("FAIL async_reset_outputs: got %h, required 0",
                     {REG_RD_ADDR1, REG_RD_ADDR2, REG_READ, REG_LAST, busy, done});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        tests++;
        if (done_total - d0 !== 0) begin fails++; $display("FAIL abort_no_done: got %0d, required 0", done_total - d0); end
        d0 = done_total; b0 = beats_total;
        issue(10'h055, 10'h0AA, 11'd1, n);
        wait_done(d0, 20, "after_reset");
        repeat (2) @(negedge clk);
        tests++;
        if (beats_total - b0 !== 1) begin fails++; $display("FAIL after_reset_beats: got %0d, required 1", beats_total - b0); end
        tests++;
        if (last_done_cyc !== n + 2) begin fails++; $display("FAIL after_reset_done_cycle: got %0d, required %0d", last_done_cyc, n + 2); end
        tests++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL after_reset_leftover: got %0d, required 0", exp_q.size()); end
    endtask

    initial begin
        fork
            monitor_beats();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_ignored_start();
        test_clamp();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
